// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: takes a WIDTH-bit word over valid/ready and shifts it out
// one bit per enabled clock, with back-to-back words sent without an idle bit between them.
module piso_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic last_bit;
    logic accept;

    // Last bit is consumed this edge: the slot is free for the next word.
    assign last_bit  = (state_q == StShift) && shift_en && (cnt_q == LastCnt);
    assign din_ready = (state_q == StIdle) || last_bit;
    assign accept    = din_ready && din_valid;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (shift_en) begin
                    if (last_bit) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (accept) begin
                            shreg_d = din;
                        end else begin
                            shreg_d = '0;
                            state_d = StIdle;
                        end
                    end else begin
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                        cnt_d   = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_comb begin
        sout_valid_d = (state_d == StShift);
        busy_d       = (state_d == StShift);
        if (state_d == StShift) begin
            sout_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end else begin
            sout_d = IDLE_LEVEL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= IDLE_LEVEL;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: expected bits are queued at word acceptance and popped
// whenever the serializer consumes a bit; a second instance covers LSB-first and idle level 1.
module tb_piso_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       shift_en;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    logic [7:0] din2;
    logic       din_valid2;
    logic       din_ready2;
    logic       shift_en2;
    logic       sout2;
    logic       sout_valid2;
    logic       busy2;
    logic       done2;

    int   vectors;
    int   miscompares;
    int   valid_cnt;
    logic exp_q[$];
    logic [7:0] rx;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .shift_en  (shift_en),
        .sout      (sout),
        .sout_valid(sout_valid),
        .busy      (busy),
        .done      (done)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .din       (din2),
        .din_valid (din_valid2),
        .din_ready (din_ready2),
        .shift_en  (shift_en2),
        .sout      (sout2),
        .sout_valid(sout_valid2),
        .busy      (busy2),
        .done      (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    // Serial-in shift register on the same clock, as the receiving end of the link.
    always @(posedge clk) begin
        if (sout_valid && shift_en) rx <= {rx[6:0], sout};
    end

    always @(negedge clk) begin
        if (sout_valid) valid_cnt++;
        if (sout_valid && shift_en && reset) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL extra_bit: observed bit %b with empty queue, expected no bit", sout);
            end else begin
                logic b;
                b = exp_q.pop_front();
                check("sout_bit", 32'(sout), 32'(b));
            end
        end
    end

    initial begin
        int dones;
        vectors     = 0;
        miscompares = 0;
        valid_cnt   = 0;
        rx          = '0;
        din2        = '0;
        din_valid2  = 1'b0;
        shift_en2   = 1'b1;

        // 1: reset held with valid/enable high
        reset     = 1'b0;
        din       = 8'hA5;
        din_valid = 1'b1;
        shift_en  = 1'b1;
        tick();
        tick();
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_sout_valid", 32'(sout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_sout_lsb", 32'(sout2), 32'd1);
        din_valid = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_sout_valid", 32'(sout_valid), 32'd0);

        // 2: single word A5
        din       = 8'hA5;
        din_valid = 1'b1;
        push_word(8'hA5);
        check("idle_ready", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0;
        din       = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check("single_busy", 32'(busy), 32'd1);
            check("single_ready", 32'(din_ready), 32'(i == 7));
            tick();
        end
        check("single_done", 32'(done), 32'd1);
        check("single_idle", 32'(busy), 32'd0);
        tick();
        check("single_done_clr", 32'(done), 32'd0);
        check("rx_word", 32'(rx), 32'hA5);

        // 3: back-to-back A5 then 3C
        din       = 8'hA5;
        din_valid = 1'b1;
        push_word(8'hA5);
        tick();
        din = 8'h3C;
        push_word(8'h3C);
        dones = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 8) din_valid = 1'b0;
            check("b2b_valid", 32'(sout_valid), 32'(i < 16));
            check("b2b_ready", 32'(din_ready), 32'(i == 7 || i == 15 || i >= 16));
            check("b2b_done", 32'(done), 32'(i == 8 || i == 16));
            if (done) dones++;
            tick();
        end
        check("b2b_done_count", 32'(dones), 32'd2);
        check("rx_word2", 32'(rx), 32'h3C);

        // 4: stall three cycles after the third bit
        din       = 8'hF0;
        din_valid = 1'b1;
        push_word(8'hF0);
        valid_cnt = 0;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        tick();
        shift_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_sout", 32'(sout), 32'd1);
            check("stall_valid", 32'(sout_valid), 32'd1);
            tick();
        end
        shift_en = 1'b1;
        for (int i = 0; i < 30 && !done; i++) tick();
        check("stall_done", 32'(done), 32'd1);
        check("stall_valid_cycles", 32'(valid_cnt), 32'd11);
        check("rx_word3", 32'(rx), 32'hF0);
        tick();

        // 5: asynchronous reset mid-word, then FF
        din       = 8'h5A;
        din_valid = 1'b1;
        push_word(8'h5A);
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("arst_sout", 32'(sout), 32'd0);
        check("arst_valid", 32'(sout_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(din_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check("arst_no_resume", 32'(busy), 32'd0);
        din       = 8'hFF;
        din_valid = 1'b1;
        push_word(8'hFF);
        tick();
        din_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            tick();
        end
        check("ff_done_count", 32'(dones), 32'd1);
        check("rx_word4", 32'(rx), 32'hFF);

        // 6: LSB-first instance with idle level 1
        check("lsb_idle_before", 32'(sout2), 32'd1);
        check("lsb_idle_valid", 32'(sout_valid2), 32'd0);
        din2       = 8'h01;
        din_valid2 = 1'b1;
        tick();
        din_valid2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb_bit", 32'(sout2), 32'(i == 0));
            check("lsb_valid", 32'(sout_valid2), 32'd1);
            tick();
        end
        check("lsb_idle_after", 32'(sout2), 32'd1);
        check("lsb_valid_after", 32'(sout_valid2), 32'd0);
        check("lsb_done", 32'(done2), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
